usb_tx_controller: RTL and testbench

- Sequences the USB transmit encoder for one packet: SYNC, PID, data bytes, optional CRC16, then EOP.
- Owns the bit timer: generates `tx_shift` and `tx_out_bit` (pre-NRZI), honours `tx_hold` stuff cycles, and pulses `create_eop`.
- Sits between the packet/protocol layer (byte stream with valid/ready) and the encoder.

---
 rtl/usb_pkg.sv | 31 +++
 rtl/usb_crc16.sv | 43 ++++
 rtl/usb_tx_controller.sv | 159 +++++++++++++++
 tb/tb_usb_tx_controller.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared definitions for the USB transmit path: PIDs, controller states, CRC16 and SYNC constants.
// The data-PID helper is only used when USB_TX_CRC16_EN is defined.
package usb_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_SYNC,
      ST_PID,
      ST_DATA,
      ST_CRC_LO,
      ST_CRC_HI,
      ST_EOP_REQ,
      ST_EOP_WAIT_HI,
      ST_EOP_WAIT_LO
   } tx_state_t;

   localparam logic [3:0]  PID_ACK    = 4'h2;
   localparam logic [3:0]  PID_DATA0  = 4'h3;
   localparam logic [3:0]  PID_DATA1  = 4'hB;
   localparam logic [3:0]  PID_DATA2  = 4'h7;
   localparam logic [3:0]  PID_MDATA  = 4'hF;

   localparam logic [15:0] CRC16_POLY = 16'h8005;
   localparam logic [15:0] CRC16_INIT = 16'hFFFF;
   localparam logic [7:0]  SYNC_BYTE  = 8'h80;

   function automatic logic is_data_pid(input logic [3:0] p);
      return (p == PID_DATA0) || (p == PID_DATA1) || (p == PID_DATA2) || (p == PID_MDATA);
   endfunction

endpackage

// File: rtl/usb_crc16.sv
// Serial USB CRC16 (poly 0x8005, init 0xFFFF) with per-bit enable and synchronous clear.
// Used by usb_tx_controller only when USB_TX_CRC16_EN is defined.
module usb_crc16
   import usb_pkg::*;
(
   input  logic        clk,
   input  logic        n_rst,
   input  logic        clear,
   input  logic        en,
   input  logic        bit_in,
   output logic [15:0] crc_out
);

   logic [15:0] crc_q;
   logic [15:0] crc_d;

   always_comb begin
      crc_d = crc_q;
      if (en) begin
         crc_d = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ bit_in) ? CRC16_POLY : '0);
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         crc_q <= CRC16_INIT;
      end else if (clear) begin
         crc_q <= CRC16_INIT;
      end else begin
         crc_q <= crc_d;
      end
   end

   // Output reflects the bit being absorbed this cycle, so the caller can load the
   // CRC byte on the same edge as the final payload bit. Bit-reversed so the low
   // byte sent LSB first puts the register MSB on the wire first.
   always_comb begin
      for (int unsigned i = 0; i < 16; i++) begin
         crc_out[i] = ~crc_d[15 - i];
      end
   end

endmodule

// File: rtl/usb_tx_controller.sv
// USB transmit sequencer: SYNC, PID, payload, optional CRC16, EOP handshake; owns the bit timer.
// Automatic CRC16 appending for data PIDs is enabled by defining USB_TX_CRC16_EN.
module usb_tx_controller
   import usb_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 8
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       start,
   input  logic [3:0] pid,
   input  logic       has_data,
   input  logic [7:0] data_byte,
   input  logic       data_valid,
   input  logic       data_last,
   output logic       data_ready,
   input  logic       tx_hold,
   input  logic       transmit_eop,
   output logic       tx_out_bit,
   output logic       tx_shift,
   output logic       create_eop,
   output logic       busy,
   output logic       done,
   output logic       err_underrun
);

   localparam int unsigned    TW     = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0]  T_LAST = TW'(CLKS_PER_BIT - 1);

   tx_state_t     state;
   logic [TW-1:0] timer;
   logic [7:0]    shreg;
   logic [2:0]    bit_idx;
   logic [3:0]    pid_q;
   logic          has_data_q;
   logic          last_q;
   logic          done_q;

   logic          bit_state;
   logic          consume;
   logic          byte_end;
   logic          need_data;
   logic          accept;

   assign bit_state  = (state == ST_SYNC) || (state == ST_PID) || (state == ST_DATA) ||
                       (state == ST_CRC_LO) || (state == ST_CRC_HI);
   assign tx_shift   = bit_state && (timer == T_LAST);
   assign consume    = tx_shift && !tx_hold;
   assign byte_end   = consume && (bit_idx == 3'd7);
   assign need_data  = ((state == ST_PID) && has_data_q) || ((state == ST_DATA) && !last_q);
   assign accept     = (state == ST_IDLE) && start && !done_q;

   assign data_ready   = byte_end && need_data && data_valid;
   assign err_underrun = byte_end && need_data && !data_valid;
   assign tx_out_bit   = shreg[0];
   assign busy         = (state != ST_IDLE);
   assign create_eop   = (state == ST_EOP_REQ);
   assign done         = done_q;

`ifdef USB_TX_CRC16_EN
   logic        crc_on_q;
   logic [15:0] crc_out;

   usb_crc16 u_crc (
      .clk     (clk),
      .n_rst   (n_rst),
      .clear   (accept),
      .en      (consume && (state == ST_DATA)),
      .bit_in  (shreg[0]),
      .crc_out (crc_out)
   );
`endif

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state      <= ST_IDLE;
         timer      <= '0;
         shreg      <= '1;
         bit_idx    <= '0;
         pid_q      <= '0;
         has_data_q <= 1'b0;
         last_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef USB_TX_CRC16_EN
         crc_on_q   <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  state      <= ST_SYNC;
                  timer      <= '0;
                  shreg      <= SYNC_BYTE;
                  bit_idx    <= '0;
                  pid_q      <= pid;
                  has_data_q <= has_data;
                  last_q     <= 1'b0;
`ifdef USB_TX_CRC16_EN
                  crc_on_q   <= is_data_pid(pid);
`endif
               end
            end
            ST_SYNC, ST_PID, ST_DATA, ST_CRC_LO, ST_CRC_HI: begin
               timer <= tx_shift ? '0 : timer + 1'b1;
               if (consume) begin
                  bit_idx <= bit_idx + 3'd1;
                  shreg   <= {1'b1, shreg[7:1]};
                  // Byte boundary: every field hand-off happens on the consuming shift of bit 7.
                  if (bit_idx == 3'd7) begin
                     if (state == ST_SYNC) begin
                        state <= ST_PID;
                        shreg <= {~pid_q, pid_q};
                     end
`ifdef USB_TX_CRC16_EN
                     else if (state == ST_CRC_LO) begin
                        state <= ST_CRC_HI;
                        shreg <= crc_out[15:8];
                     end
`endif
                     else if (need_data && data_valid) begin
                        state  <= ST_DATA;
                        shreg  <= data_byte;
                        last_q <= data_last;
                     end
`ifdef USB_TX_CRC16_EN
                     else if (!need_data && crc_on_q && (state != ST_CRC_HI)) begin
                        state <= ST_CRC_LO;
                        shreg <= crc_out[7:0];
                     end
`endif
                     else begin
                        state <= ST_EOP_REQ;
                        shreg <= '1;
                        timer <= '0;
                     end
                  end
               end
            end
            ST_EOP_REQ: begin
               state <= ST_EOP_WAIT_HI;
            end
            ST_EOP_WAIT_HI: begin
               if (transmit_eop) state <= ST_EOP_WAIT_LO;
            end
            ST_EOP_WAIT_LO: begin
               if (!transmit_eop) begin
                  state  <= ST_IDLE;
                  done_q <= 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_usb_tx_controller.sv
// Self-checking bench for usb_tx_controller: bit-stream, stuffing, CRC, EOP handshake, underrun, reset.
// CRC expectations follow USB_TX_CRC16_EN when it is defined for the build.
module tb_usb_tx_controller;

   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic       start = 1'b0;
   logic [3:0] pid = '0;
   logic       has_data = 1'b0;
   logic [7:0] data_byte = '0;
   logic       data_valid = 1'b0;
   logic       data_last = 1'b0;
   logic       tx_hold = 1'b0;
   logic       transmit_eop = 1'b0;
   logic       data_ready, tx_out_bit, tx_shift, create_eop, busy, done, err_underrun;

   int compares = 0;
   int fails = 0;
   logic [7:0] pay [16];

   always #5 clk = ~clk;

   usb_tx_controller #(.CLKS_PER_BIT(CPB)) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .start        (start),
      .pid          (pid),
      .has_data     (has_data),
      .data_byte    (data_byte),
      .data_valid   (data_valid),
      .data_last    (data_last),
      .data_ready   (data_ready),
      .tx_hold      (tx_hold),
      .transmit_eop (transmit_eop),
      .tx_out_bit   (tx_out_bit),
      .tx_shift     (tx_shift),
      .create_eop   (create_eop),
      .busy         (busy),
      .done         (done),
      .err_underrun (err_underrun)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compares++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reflected CRC-16/USB over whole bytes, complemented.
   function automatic logic [15:0] crc16_ref(input logic [7:0] b[$]);
      logic [15:0] c = 16'hFFFF;
      foreach (b[i]) begin
         for (int j = 0; j < 8; j++) begin
            if ((c[0] ^ b[i][j]) == 1'b1) c = (c >> 1) ^ 16'hA001;
            else c = c >> 1;
         end
      end
      return ~c;
   endfunction

   function automatic bit is_data(input logic [3:0] p);
      return (p == 4'h3) || (p == 4'hB) || (p == 4'h7) || (p == 4'hF);
   endfunction

   // A stuff (hold) is needed after six ones, provided another bit still follows.
   function automatic int holds_for(input bit b[$]);
      int ones = 0;
      int h = 0;
      for (int i = 0; i < b.size(); i++) begin
         if (b[i]) ones++;
         else ones = 0;
         if (ones == 6) begin
            ones = 0;
            if (i < b.size() - 1) h++;
         end
      end
      return h;
   endfunction

   function automatic logic [6:0] outs();
      return {tx_out_bit, tx_shift, create_eop, busy, done, data_ready, err_underrun};
   endfunction

   task automatic send_packet(input string tag, input logic [3:0] p, input logic hd,
                              input int nbytes, input int miss_at, input bit poke);
      logic [7:0] exp_q[$];
      logic [7:0] sent_q[$];
      bit         exp_bits[$];
      bit         cap[$];
      logic [15:0] crc;
      logic [31:0] got;
      logic       first_out = 1'bx;
      logic       busy_after = 1'bx;
      int first_shift = -1, last_shift = -1, last_cons = -1;
      int eop_k = -1, done_k = -1;
      int ready_cnt = 0, under_cnt = 0, eop_cnt = 0, done_cnt = 0, holds = 0;
      int idx = 0, ones = 0, exp_under;
      bit stuff_pend = 0, timing_ok = 1, stable_ok = 1, eop_shift = 0;
      logic prev_out = 1'b1;

      exp_q.push_back(8'h80);
      exp_q.push_back({~p, p});
      if (hd) begin
         for (int i = 0; i < nbytes; i++) begin
            if (i == miss_at) break;
            sent_q.push_back(pay[i]);
         end
      end
      foreach (sent_q[i]) exp_q.push_back(sent_q[i]);
      exp_under = (hd && miss_at >= 0 && miss_at < nbytes) ? 1 : 0;
`ifdef USB_TX_CRC16_EN
      if (is_data(p) && exp_under == 0) begin
         crc = crc16_ref(sent_q);
         exp_q.push_back(crc[7:0]);
         exp_q.push_back(crc[15:8]);
      end
`endif
      foreach (exp_q[i]) for (int j = 0; j < 8; j++) exp_bits.push_back(exp_q[i][j]);

      @(negedge clk);
      start = 1'b1; pid = p; has_data = hd;
      tx_hold = 1'b0; data_valid = 1'b0; transmit_eop = 1'b0;
      for (int k = 1; k < 4000; k++) begin
         @(negedge clk);
         start = poke && (k == 20 || (eop_k >= 0 && k == eop_k + 6));
         pid = ~p; has_data = ~hd;
         tx_hold = stuff_pend;
         data_valid = hd && idx < nbytes && idx != miss_at;
         data_byte = (idx < 16) ? pay[idx] : 8'h00;
         data_last = (idx == nbytes - 1);
         transmit_eop = (eop_k >= 0 && k >= eop_k + 2 && k < eop_k + 5);
         #1;
         if (k == 1) first_out = tx_out_bit;
         if (k > 1 && tx_out_bit !== prev_out && last_cons != k - 1) stable_ok = 0;
         prev_out = tx_out_bit;
         if (tx_shift) begin
            if (first_shift < 0) first_shift = k;
            else if (k - last_shift != CPB) timing_ok = 0;
            last_shift = k;
            if (tx_hold) begin
               stuff_pend = 0;
               holds++;
            end else begin
               cap.push_back(tx_out_bit);
               last_cons = k;
               if (tx_out_bit) begin
                  ones++;
                  if (ones == 6) begin stuff_pend = 1; ones = 0; end
               end else ones = 0;
            end
         end
         if (data_ready) begin ready_cnt++; idx++; end
         if (err_underrun) under_cnt++;
         if (create_eop) begin
            eop_cnt++;
            if (eop_k < 0) eop_k = k;
            if (tx_shift) eop_shift = 1;
         end
         if (done) begin
            done_cnt++;
            if (done_k < 0) done_k = k;
         end
         if (done_k >= 0 && k == done_k + 1) busy_after = busy;
         if (done_k >= 0 && k == done_k + 2) break;
      end
      start = 1'b0; data_valid = 1'b0; tx_hold = 1'b0; transmit_eop = 1'b0;

      chk({tag, " first_bit"}, first_out, 0);
      chk({tag, " first_shift"}, first_shift, CPB);
      chk({tag, " shift_period"}, timing_ok, 1);
      chk({tag, " bit_stable"}, stable_ok, 1);
      chk({tag, " bit_count"}, cap.size(), exp_bits.size());
      foreach (exp_q[j]) begin
         got = 32'hDEAD;
         if (cap.size() >= 8 * (j + 1)) begin
            got = '0;
            for (int i = 0; i < 8; i++) got[i] = cap[8 * j + i];
         end
         chk($sformatf("%s byte%0d", tag, j), got, exp_q[j]);
      end
      chk({tag, " holds"}, holds, holds_for(exp_bits));
      chk({tag, " data_ready_cnt"}, ready_cnt, sent_q.size());
      chk({tag, " underrun_cnt"}, under_cnt, exp_under);
      chk({tag, " eop_cnt"}, eop_cnt, 1);
      chk({tag, " eop_latency"}, eop_k - last_cons, 1);
      chk({tag, " eop_no_shift"}, eop_shift, 0);
      chk({tag, " done_cnt"}, done_cnt, 1);
      chk({tag, " done_latency"}, done_k - eop_k, 6);
      chk({tag, " idle_after_done"}, busy_after, 0);
   endtask

   initial begin
      logic [3:0] pids [6] = '{4'h3, 4'hB, 4'h7, 4'hF, 4'h1, 4'h9};
      bit seen;

      repeat (3) @(negedge clk);
      #1;
      chk("reset_outputs", outs(), 7'b1000000);
      @(negedge clk);
      n_rst = 1'b1;

      send_packet("ack", 4'h2, 1'b0, 0, -1, 1'b0);
      send_packet("zlp_data0", 4'h3, 1'b0, 0, -1, 1'b0);

      pay[0] = 8'hFF; pay[1] = 8'hFF;
      send_packet("ffff", 4'h3, 1'b1, 2, -1, 1'b0);

      for (int i = 0; i < 3; i++) pay[i] = 8'($urandom);
      send_packet("underrun", 4'hB, 1'b1, 3, 1, 1'b0);

      send_packet("start_busy", 4'h2, 1'b0, 0, -1, 1'b1);

      @(negedge clk);
      start = 1'b1; pid = 4'h3; has_data = 1'b1;
      data_valid = 1'b1; data_byte = 8'h55; data_last = 1'b0; tx_hold = 1'b0;
      @(negedge clk);
      start = 1'b0;
      seen = 0;
      for (int k = 0; k < 400 && !seen; k++) begin
         @(negedge clk);
         #1;
         if (data_ready) seen = 1;
      end
      chk("rst_reached_data", seen, 1);
      @(negedge clk);
      n_rst = 1'b0;
      #1;
      chk("rst_mid_data_outputs", outs(), 7'b1000000);
      data_valid = 1'b0;
      @(negedge clk);
      n_rst = 1'b1;

      pay[0] = 8'($urandom); pay[1] = 8'($urandom);
      send_packet("after_reset", 4'h3, 1'b1, 2, -1, 1'b0);

      for (int r = 0; r < 6; r++) begin
         int n = int'($urandom_range(1, 6));
         for (int i = 0; i < n; i++) pay[i] = 8'($urandom);
         send_packet($sformatf("rand%0d", r), pids[$urandom_range(0, 5)], 1'b1, n, -1, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
      $finish;
   end

endmodule
